// File: rtl/ysyx_24110015_if_id_buf_if.sv
// Valid/ready bus carrying one {pc, inst} pair.
// Fetch and decode sides of the IF/ID buffer.
interface ysyx_24110015_if_id_buf_if;
  logic        valid;
  logic        ready;
  logic [31:0] pc;
  logic [31:0] inst;

  modport master (
    output valid,
    output pc,
    output inst,
    input  ready
  );

  modport slave (
    input  valid,
    input  pc,
    input  inst,
    output ready
  );
endinterface

// File: rtl/ysyx_24110015_if_id_buf.sv
// Two-entry IF/ID instruction buffer with flush.
// Also counts decode-stall cycles, saturating.
module ysyx_24110015_if_id_buf (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  ysyx_24110015_if_id_buf_if.slave           fetch,
  ysyx_24110015_if_id_buf_if.master          decode,
  output logic [1:0]                         count,
  output logic [31:0]                        stall_cycles
);

  logic [31:0] pc_q   [2];
  logic [31:0] inst_q [2];
  logic        wp;
  logic        rp;
  logic [1:0]  cnt;
  logic [31:0] stall_q;
  logic        push;
  logic        pop;
  logic        stall;

  // Handshake outputs come from registered occupancy only.
  assign fetch.ready  = (cnt != 2'd2);
  assign decode.valid = (cnt != 2'd0);
  assign decode.pc    = pc_q[rp];
  assign decode.inst  = inst_q[rp];

  assign push  = fetch.valid & fetch.ready & ~flush;
  assign pop   = decode.valid & decode.ready & ~flush;
  assign stall = decode.valid & ~decode.ready & ~flush;

  assign count        = cnt;
  assign stall_cycles = stall_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
      end
      wp  <= 1'b0;
      rp  <= 1'b0;
      cnt <= 2'd0;
    end else if (flush) begin
      wp  <= 1'b0;
      rp  <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (push) begin
        pc_q[wp]   <= fetch.pc;
        inst_q[wp] <= fetch.inst;
        wp         <= ~wp;
      end
      if (pop) begin
        rp <= ~rp;
      end
      unique case (1'b1)
        push & ~pop: cnt <= cnt + 2'd1;
        pop & ~push: cnt <= cnt - 2'd1;
        default:     cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_q <= '0;
    end else if (stall && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_ysyx_24110015_if_id_buf.sv
// Directed bench for the IF/ID buffer.
// A bench-side FIFO model predicts every output.
module tb_ysyx_24110015_if_id_buf;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [1:0]  count;
  logic [31:0] stall_cycles;

  ysyx_24110015_if_id_buf_if f_bus ();
  ysyx_24110015_if_id_buf_if d_bus ();

  ysyx_24110015_if_id_buf dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .fetch        (f_bus),
    .decode       (d_bus),
    .count        (count),
    .stall_cycles (stall_cycles)
  );

  localparam logic [31:0] MAGIC = 32'h5A5A_0013;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [63:0] q [$];
  int          mcnt  = 0;
  logic [31:0] mstall = '0;
  bit          known = 1'b0;
  int          npop  = 0;
  logic [31:0] last_pc = '0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cycle(input logic iv, input logic [31:0] ipc,
                       input logic ordy, input logic fl,
                       input logic r, output logic acc);
    logic pp;
    rst          = r;
    flush        = fl;
    f_bus.valid  = iv;
    f_bus.pc     = ipc;
    f_bus.inst   = ipc ^ MAGIC;
    d_bus.ready  = ordy;
    #1;
    if (known) begin
      chk("in_ready", 64'(f_bus.ready), 64'(mcnt != 2));
      chk("out_valid", 64'(d_bus.valid), 64'(mcnt != 0));
      chk("count", 64'(count), 64'(mcnt));
      chk("stall", 64'(stall_cycles), 64'(mstall));
      if (mcnt != 0) begin
        chk("out_pc", 64'(d_bus.pc), q[0] >> 32);
        chk("out_inst", 64'(d_bus.inst), 64'(q[0][31:0]));
      end
    end
    acc = 1'b0;
    if (!r) begin
      q.delete();
      mcnt   = 0;
      mstall = '0;
      known  = 1'b1;
    end else begin
      acc = iv && (mcnt != 2) && !fl;
      pp  = (mcnt != 0) && ordy && !fl;
      if ((mcnt != 0) && !ordy && !fl && (mstall != 32'hFFFF_FFFF))
        mstall = mstall + 1;
      if (fl) begin
        q.delete();
      end else begin
        if (pp) begin
          last_pc = q[0][63:32];
          npop++;
          void'(q.pop_front());
        end
        if (acc) q.push_back({ipc, ipc ^ MAGIC});
      end
      mcnt = q.size();
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic        a;
    logic [31:0] pc;
    int          guard;
    rst = 1'b0; flush = 1'b0;
    f_bus.valid = 1'b0; f_bus.pc = '0; f_bus.inst = '0;
    d_bus.ready = 1'b0;
    @(negedge clk);

    // reset held two cycles with in_valid high
    cycle(1'b1, 32'h8000_0000, 1'b1, 1'b0, 1'b0, a);
    cycle(1'b1, 32'h8000_0000, 1'b1, 1'b0, 1'b0, a);
    rst = 1'b1; #1;
    chk("rst_pc", 64'(d_bus.pc), 64'h0);
    chk("rst_inst", 64'(d_bus.inst), 64'h0);
    chk("rst_cnt", 64'(count), 64'h0);

    // streaming
    cycle(1'b1, 32'h8000_0000, 1'b1, 1'b0, 1'b1, a);
    cycle(1'b1, 32'h8000_0004, 1'b1, 1'b0, 1'b1, a);
    cycle(1'b1, 32'h8000_0008, 1'b1, 1'b0, 1'b1, a);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, a);
    chk("stream_last", 64'(last_pc), 64'h8000_0008);
    chk("stream_stall", 64'(stall_cycles), 64'h0);

    // backpressure
    cycle(1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b1, a);
    cycle(1'b1, 32'h8000_0004, 1'b0, 1'b0, 1'b1, a);
    pc = 32'h8000_0008;
    cycle(1'b1, pc, 1'b0, 1'b0, 1'b1, a);
    chk("bp_reject", 64'(a), 64'h0);
    cycle(1'b1, pc, 1'b0, 1'b0, 1'b1, a);
    chk("bp_stall3", 64'(stall_cycles), 64'd3);
    guard = 0;
    while (mcnt != 0 && guard < 20) begin
      cycle(!a, pc, 1'b1, 1'b0, 1'b1, a);
      guard++;
    end
    chk("bp_drain", 64'(mcnt == 0), 64'h1);
    chk("bp_last", 64'(last_pc), 64'h8000_0008);

    // flush with full buffer and concurrent push
    cycle(1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b1, a);
    cycle(1'b1, 32'h8000_0004, 1'b0, 1'b0, 1'b1, a);
    cycle(1'b1, 32'h8000_0010, 1'b0, 1'b1, 1'b1, a);
    cycle(1'b1, 32'h8000_0100, 1'b1, 1'b0, 1'b1, a);
    chk("fl_acc", 64'(a), 64'h1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, a);
    chk("fl_first", 64'(last_pc), 64'h8000_0100);

    // wrap-around with random decode stalls
    npop = 0;
    pc   = 32'h8000_0200;
    guard = 0;
    while ((pc != 32'h8000_0228) && guard < 200) begin
      cycle(1'b1, pc, 1'($urandom_range(0, 1)), 1'b0, 1'b1, a);
      if (a) pc = pc + 4;
      guard++;
    end
    guard = 0;
    while (mcnt != 0 && guard < 20) begin
      cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, a);
      guard++;
    end
    chk("wrap_n", 64'(npop), 64'd10);
    chk("wrap_last", 64'(last_pc), 64'h8000_0224);

    // saturation of the stall counter
    cycle(1'b1, 32'h8000_0300, 1'b0, 1'b0, 1'b1, a);
    force dut.stall_q = 32'hFFFF_FFFD;
    #1;
    release dut.stall_q;
    mstall = 32'hFFFF_FFFD;
    for (int i = 0; i < 5; i++)
      cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, a);
    chk("sat", 64'(stall_cycles), 64'hFFFF_FFFF);

    // reset mid-operation
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, a);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, a);
    chk("rst2_stall", 64'(stall_cycles), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_24110015_if_id_buf.md
# ysyx_24110015_if_id_buf

Two-entry instruction buffer between the fetch unit (IFU) and the decode unit (IDU) in the ysyx_24110015 NPC core. It accepts {pc, inst} pairs from fetch over a valid/ready handshake and presents them in order to decode. It decouples a stalled decode from fetch without a combinational ready path, and discards all buffered instructions on a pipeline flush (branch/jump/trap redirect). It also carries a saturating decode-stall cycle counter for performance reporting.

## Interface
- No parameters; depth fixed at 2 entries, data 32-bit pc + 32-bit inst.
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-low.
- flush  input  1  discard all entries and any same-cycle push.
- in_valid  input  1  fetch presents a valid {in_pc, in_inst}.
- in_ready  output  1  buffer can accept; registered, depends only on occupancy.
- in_pc  input  32  PC of the fetched instruction.
- in_inst  input  32  instruction word from pmem.
- out_valid  output  1  head entry valid for decode.
- out_ready  input  1  decode consumes the head this cycle.
- out_pc  output  32  PC of head entry.
- out_inst  output  32  instruction of head entry.
- count  output  2  occupancy, 0..2.
- stall_cycles  output  32  cycles with out_valid=1 and out_ready=0, saturating.

## Operation
- Storage: two slots {pc, inst}, write pointer wp, read pointer rp (1 bit each, wrap 1->0), occupancy count.
- push = in_valid & in_ready & ~flush; pop = out_valid & out_ready & ~flush.
- in_ready = (count != 2); out_valid = (count != 0). Both derived from registered count only.
- push: slot[wp] <= {in_pc, in_inst}; wp <= wp+1.
- pop: rp <= rp+1.
- count update: push&~pop -> +1; pop&~push -> -1; push&pop -> unchanged (only possible at count=1); neither -> unchanged.
- out_pc/out_inst = slot[rp]; meaningful only when out_valid=1; decode must ignore them otherwise.
- flush (priority over push and pop): count<=0, wp<=0, rp<=0; slot contents untouched; same-cycle in_valid discarded; stall_cycles not affected.
- stall_cycles: increments by 1 each cycle out_valid=1 & out_ready=0 & ~flush; holds at 32'hFFFF_FFFF.
- Ordering: strict FIFO; no reordering or duplication; an entry is popped exactly once.
- in_valid while in_ready=0: no state change; fetch must hold data (handshake protocol: in_pc/in_inst stable until accepted).

## Timing
- Reset (rst=0 at posedge): count=0, wp=rp=0, all slots 0, stall_cycles=0; thus in_ready=1, out_valid=0, out_pc=0, out_inst=0 after that edge. Reset overrides flush, push and pop.
- Latency: entry pushed at edge N appears with out_valid=1 after edge N (visible cycle N+1); no same-cycle bypass.
- Throughput: one entry/cycle sustained when decode always ready (count steady at 1).
- Full (count=2): in_ready=0 next cycle; a pop at count=2 raises in_ready one cycle later (no combinational out_ready->in_ready path).
- Empty: out_valid=0; out_ready ignored.
- Flush at edge N: out_valid=0, in_ready=1 from cycle N+1; first post-flush push accepted at edge N+1 earliest.
- Reset mid-operation: all entries lost, same values as power-on reset.

## Test plan
- Reset: hold rst=0 two cycles with in_valid=1 -> count=0, out_valid=0, in_ready=1, stall_cycles=0, out_pc=0.
- Streaming: push pc 0x80000000,0x80000004,0x80000008 back-to-back, out_ready=1 -> out_pc sequence identical, each one cycle after push, count stays 1, stall_cycles=0.
- Backpressure: out_ready=0, push 0x80000000, 0x80000004, offer 0x80000008 -> count=2, in_ready=0, third not accepted; release out_ready -> outputs 0x80000000, 0x80000004, then 0x80000008 after it is accepted; stall_cycles equals cycles held.
- Flush: count=2, assert flush with in_valid=1 (pc 0x80000010) -> next cycle count=0, out_valid=0; 0x80000010 never appears; next push 0x80000100 is first output.
- Wrap-around: 10 alternating push/pop pairs with random out_ready stalls -> all PCs out in order, no loss or duplicate, wp/rp wrap cleanly.
- Saturation: force stall_cycles near 32'hFFFF_FFFE, hold stall 5 cycles -> stays 32'hFFFF_FFFF.
